// File: rtl/multipit_if.sv
// Bus bundle for the multi-channel interval timer: configuration writes,
// interrupt clears, count readback and the expiry/interrupt outputs.
interface multipit_if #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_WIDTH-1:0] prescale;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [WIDTH-1:0]     cfg_reload;
  logic                 cfg_enable;
  logic                 cfg_repeat;
  logic [NUM_CH-1:0]    irq_clear;
  logic [CH_W-1:0]      cnt_sel;
  logic [WIDTH-1:0]     cnt_value;
  logic [NUM_CH-1:0]    expire;
  logic [NUM_CH-1:0]    irq_pending;
  logic                 irq;

  // Timer side
  modport slave (
    input  prescale, cfg_we, cfg_ch, cfg_reload, cfg_enable, cfg_repeat,
    input  irq_clear, cnt_sel,
    output cnt_value, expire, irq_pending, irq
  );

  // Register front-end / interrupt aggregator side
  modport master (
    output prescale, cfg_we, cfg_ch, cfg_reload, cfg_enable, cfg_repeat,
    output irq_clear, cnt_sel,
    input  cnt_value, expire, irq_pending, irq
  );
endinterface

// File: rtl/multipit.sv
// Multi-channel programmable interval timer. One free-running prescaler
// produces a shared tick; each channel is an independent down-counter with
// one-shot or repeating reload and a sticky W1C pending flag.

// One timer channel: IDLE/RUN FSM with registered count, expire and pending.
module multipit_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_reload,
  input  logic             wr_enable,
  input  logic             wr_repeat,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             pending
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             rep;
  logic             hit;

  // Expiry: a running channel sitting at zero when the tick arrives
  assign hit = tick && (state == RUN) && (count == '0);

  // Channel FSM; a config write overrides the counting update, but the
  // expiry still raises expire/pending, and a set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      rep     <= 1'b0;
      expire  <= 1'b0;
      pending <= 1'b0;
    end else begin
      expire <= hit;
      if (hit)      pending <= 1'b1;
      else if (clr) pending <= 1'b0;

      if (wr) begin
        reload <= wr_reload;
        count  <= wr_reload;
        rep    <= wr_repeat;
        state  <= wr_enable ? RUN : IDLE;
      end else if (tick && state == RUN) begin
        if (count != '0) count <= count - 1'b1;
        else if (rep)    count <= reload;
        else             state <= IDLE;
      end
    end
  end
endmodule

module multipit #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  multipit_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_WIDTH-1:0]          pre_cnt;
  logic                          tick;
  logic [NUM_CH-1:0][WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]              cnt_mux;

  // >= rather than == so lowering prescale below pre_cnt ticks at once
  assign tick = (pre_cnt >= bus.prescale);

  // Free-running prescaler; config writes never disturb its phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Only in-range channels exist, so out-of-range cfg_ch matches nothing
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    multipit_ch #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .wr        (bus.cfg_we && (bus.cfg_ch == CH_W'(gi))),
      .wr_reload (bus.cfg_reload),
      .wr_enable (bus.cfg_enable),
      .wr_repeat (bus.cfg_repeat),
      .clr       (bus.irq_clear[gi]),
      .count     (cnt[gi]),
      .expire    (bus.expire[gi]),
      .pending   (bus.irq_pending[gi])
    );
  end

  // Count readback mux; unpopulated selects read as zero
  always_comb begin
    cnt_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.cnt_sel == CH_W'(i)) cnt_mux = cnt[i];
  end

  assign bus.cnt_value = cnt_mux;
  assign bus.irq       = |bus.irq_pending;
endmodule

// File: doc/multipit.md
# multipit

Multi-channel programmable interval timer with a shared prescaler, per-channel one-shot/repeating mode and sticky, individually clearable interrupt status. It is the parametrised successor of the single-channel interval timer and sits between the configuration bus front-end (JTAG/register decode) and the interrupt aggregation logic. Each channel raises a one-cycle expiry pulse and a level pending flag; `irq` is the OR of all pending flags.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent timer channels (1..16).
- `WIDTH`, 16: counter/reload width in bits (2..32).
- `PRE_WIDTH`, 8: prescaler width in bits (1..16).
- `CH_W`: local, `$clog2(NUM_CH)` (minimum 1).

Ports:
- `clk` in 1: sole clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `prescale` in PRE_WIDTH: tick every `prescale+1` clocks; global to all channels.
- `cfg_we` in 1: configuration write strobe, one cycle.
- `cfg_ch` in CH_W: channel addressed by the write.
- `cfg_reload` in WIDTH: reload value; period is `cfg_reload+1` ticks.
- `cfg_enable` in 1: channel runs when 1.
- `cfg_repeat` in 1: 1 = reload and continue on expiry, 0 = one-shot.
- `irq_clear` in NUM_CH: write-1-to-clear for pending flags.
- `cnt_sel` in CH_W: channel whose count appears on `cnt_value`.
- `cnt_value` out WIDTH: combinational view of the selected channel's current count.
- `expire` out NUM_CH: registered one-cycle pulse per channel on expiry.
- `irq_pending` out NUM_CH: registered sticky pending flags.
- `irq` out 1: OR-reduction of `irq_pending`.

## Operation
- Prescaler: `pre_cnt` (PRE_WIDTH). `tick = (pre_cnt >= prescale)`. On tick `pre_cnt <= 0`, else `pre_cnt <= pre_cnt + 1`. `>=` guarantees recovery when `prescale` is lowered below `pre_cnt`. `prescale=0` gives a tick every cycle. Config writes never reset the prescaler.
- Per-channel state: `count`, `reload` (WIDTH), `en`, `rep`, `pending`, `expire`.
- Config write (`cfg_we`, `cfg_ch < NUM_CH`): `reload <= cfg_reload`, `count <= cfg_reload`, `en <= cfg_enable`, `rep <= cfg_repeat`. `cfg_ch >= NUM_CH` is ignored.
- Counting, on `tick && en`:
  - `count != 0`: `count <= count - 1`.
  - `count == 0`: expiry. `expire <= 1`, `pending <= 1`. If `rep`, `count <= reload`. Otherwise `en <= 0` and `count` stays 0.
- `expire` is 0 in every cycle with no expiry. A disabled channel holds its count.
- Arithmetic is unsigned modulo 2^WIDTH. No underflow can occur because 0 is the terminal state.
- Channel state is a two-level FSM: IDLE (`en=0`) and RUN (`en=1`).
  - IDLE to RUN on a write with `cfg_enable=1`.
  - RUN to IDLE on a write with `cfg_enable=0`, or on one-shot expiry.

## Timing
- Reset (async assert, sync release): `pre_cnt`, `count`, `reload`, `en`, `rep`, `pending`, `expire` all 0. Therefore `irq=0` and `cnt_value=0`. Reset mid-count aborts immediately, with no expiry pulse.
- Latency: with `prescale=0`, a write at edge E0 loads `count=R`. Expiry is evaluated at edge E(R+1), and `expire`/`pending` are high in the cycle after E(R+1). Repeating period is exactly R+1 ticks. `R=0` with repeat expires on every tick.
- With prescale P, the period is `(R+1)*(P+1)` clocks in steady state. Phase of the first expiry depends on the free-running `pre_cnt`.
- Simultaneous write and expiry on the same channel: the write wins for `count`/`reload`/`en`/`rep`. `pending` and `expire` are still set by the expiry.
- Simultaneous `irq_clear[i]` and expiry on channel i: set wins, so `pending` stays 1.
- `irq_clear` of a non-pending channel has no effect.
- `irq` is combinational from registered `irq_pending`, so it adds no extra cycle.
- Expiries on different channels are fully independent and may coincide.

## Test plan
- Reset: assert `rst_n=0` mid-run with channel 1 `R=5` repeat → all outputs 0 asynchronously. After release, nothing fires until a new config write.
- One-shot: `prescale=0`, ch0 `R=3`, enable, repeat=0 written at E0 → `expire[0]` high only in the cycle after E4. `cnt_value` (sel 0) reads 3,2,1,0 then holds 0. `en` clears and no further pulse follows.
- Repeating with prescale: `prescale=2`, ch2 `R=1` repeat → `expire[2]` pulses every 6 clocks. `irq_pending[2]` stays 1 until `irq_clear=4'b0100`, then drops the next cycle.
- Set-vs-clear: assert `irq_clear[0]` in the same cycle ch0 expires → `irq_pending[0]` remains 1. A clear one cycle later drops it to 0 and `irq` falls.
- Write collision: rewrite ch3 with `R=7` on its expiry edge → `expire[3]` still pulses, count reloads to 7 and the next expiry comes 8 ticks later. A separate write with `cfg_ch=NUM_CH` (NUM_CH=3) changes nothing.
- Prescale shrink: with `pre_cnt=200`, change `prescale` from 255 to 10 → a tick occurs on the next edge, and ticks then arrive every 11 clocks.
